// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared state encoding, select values and counter width for the clock switch controller
package clk_ctrl_pkg;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_IDLE = 3'd1;
  localparam logic [2:0] GATE_OFF  = 3'd2;
  localparam logic [2:0] SWITCH    = 3'd3;
  localparam logic [2:0] SETTLE_ON = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic SEL_CLK1 = 1'b1;
  localparam logic SEL_CLK2 = 1'b0;
  localparam int CNT_W = 8;
endpackage

// File: rtl/clk_sw_timer.sv
// clk_sw_timer: loadable down-counter that holds at zero and flags it
module clk_sw_timer
  import clk_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequences clock mux select behind a frame-idle wait and gated settle windows; CLK_SW_TIMEOUT_EN adds a wait timeout
module clk_switch_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter bit RESET_SEL      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic req_sel,
  input  logic frame_idle,
  output logic sel,
  output logic gate_en,
  output logic busy,
  output logic ack,
  output logic err
);
  logic [2:0] state, nxt;
  logic tgt, st_zero, timeout;
  wire  settling = state == GATE_OFF || state == SETTLE_ON;
  // settle counter reloads whenever no settle phase is running, so it is primed on entry
  clk_sw_timer #(.W(CNT_W)) u_settle (
    .clk(clk), .rst(rst), .load(!settling), .dec(settling),
    .val(CNT_W'(SETTLE_CYCLES - 1)), .zero(st_zero)
  );
`ifdef CLK_SW_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic to_zero;
  clk_sw_timer #(.W(TO_W)) u_timeout (
    .clk(clk), .rst(rst), .load(state != WAIT_IDLE), .dec(state == WAIT_IDLE),
    .val(TO_W'(TIMEOUT_CYCLES - 1)), .zero(to_zero)
  );
  assign timeout = state == WAIT_IDLE && to_zero;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = !req ? IDLE : (req_sel == sel) ? DONE : WAIT_IDLE;
      WAIT_IDLE: nxt = frame_idle ? GATE_OFF : timeout ? DONE : WAIT_IDLE;
      GATE_OFF:  nxt = st_zero ? SWITCH : GATE_OFF;
      SWITCH:    nxt = SETTLE_ON;
      SETTLE_ON: nxt = st_zero ? DONE : SETTLE_ON;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state   <= IDLE;
      tgt     <= RESET_SEL;
      sel     <= RESET_SEL;
      gate_en <= 1'b1;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= nxt;
      tgt     <= (state == IDLE && req) ? req_sel : tgt;
      sel     <= (state == SWITCH) ? tgt : sel;
      gate_en <= !(nxt inside {GATE_OFF, SWITCH, SETTLE_ON});
      busy    <= nxt inside {WAIT_IDLE, GATE_OFF, SWITCH, SETTLE_ON};
      // leaving WAIT_IDLE straight to DONE only happens on timeout
      ack     <= nxt == DONE && state != WAIT_IDLE;
      err     <= nxt == DONE && state == WAIT_IDLE;
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: directed vector bench for clk_switch_ctrl (timeout case built with CLK_SW_TIMEOUT_EN)
module tb_clk_switch_ctrl;
  localparam int S = 8;
  localparam int T = 16;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, req_sel = 1'b0, frame_idle = 1'b0;
  logic sel, gate_en, busy, ack, err;
  int checks = 0, errors = 0;

  clk_switch_ctrl #(.SETTLE_CYCLES(S), .RESET_SEL(1'b1), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_sel(req_sel), .frame_idle(frame_idle),
    .sel(sel), .gate_en(gate_en), .busy(busy), .ack(ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, req, req_sel, fi;
    logic [4:0] exp;
    string name;
  } vec_t;
  vec_t vecs[9];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // expected packed as {sel, gate_en, busy, ack, err}
  task automatic check(input string name, input logic [4:0] exp);
    checks++;
    if ({sel, gate_en, busy, ack, err} !== exp) begin
      errors++;
      $display("FAIL %s: sel/gate_en/busy/ack/err got %b expected %b", name,
               {sel, gate_en, busy, ack, err}, exp);
    end
  endtask

  // req at cycle 0; frame_idle first seen at idle_at (one-cycle pulse if pulse); optional dropped req at drop_at
  task automatic run_switch(input string name, input logic tgt, input int idle_at,
                            input bit pulse, input int drop_at);
    int g, flip, done;
    g = idle_at + 1;
    flip = g + S + 1;
    done = g + 2 * S + 1;
    for (int k = 1; k <= done + 1; k++) begin
      req = (k - 1 == 0) || (k - 1 == drop_at);
      req_sel = (k - 1 == 0) ? tgt : !tgt;
      frame_idle = pulse ? (k - 1 == idle_at) : (k - 1 >= idle_at);
      step;
      check($sformatf("%s k=%0d", name, k),
            {(k >= flip) ? tgt : !tgt, !(k >= g && k < done), k < done, k == done, 1'b0});
    end
    req = 1'b0;
    frame_idle = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "reset_a"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, "reset_b"};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, "idle"};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11010, "noop_ack"};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, "noop_after"};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11010, "held_ack1"};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11000, "held_in_done"};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b11010, "held_ack2"};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, "held_release"};
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst;
      req = vecs[i].req;
      req_sel = vecs[i].req_sel;
      frame_idle = vecs[i].fi;
      step;
      check(vecs[i].name, vecs[i].exp);
    end
    run_switch("normal", 1'b0, 1, 1'b0, 4);
    run_switch("deferred", 1'b1, 50, 1'b1, -1);
    req = 1'b1;
    req_sel = 1'b0;
    frame_idle = 1'b1;
    step;
    req = 1'b0;
    for (int k = 2; k <= 12; k++) step;
    check("pre_reset", 5'b00100);
    rst = 1'b1;
    step;
    check("mid_reset", 5'b11000);
    rst = 1'b0;
    frame_idle = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step;
      check($sformatf("post_reset k=%0d", k), 5'b11000);
    end
`ifdef CLK_SW_TIMEOUT_EN
    req = 1'b1;
    req_sel = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step;
      req = 1'b0;
      check($sformatf("timeout k=%0d", k), (k < T + 1) ? 5'b11100 : (k == T + 1) ? 5'b11001 : 5'b11000);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequences the select line of the two-input clock mux so that a source change is never made while the image pipeline is active.
- Accepts a switch request and waits for a frame-idle window before acting.
- Gates the downstream clock enable off, flips the select, waits for settling, then re-enables and acknowledges.
- Sits between the top-level mode/config logic and the clock mux plus its downstream enable.

Parameters:
- SETTLE_CYCLES, 8: cycles gate_en stays low before and after the select flip; legal range 1..255.
- RESET_SEL, 1: sel value after reset (1 = clk1 source, 0 = clk2 source).
- TIMEOUT_CYCLES, 1024: maximum cycles spent waiting for frame_idle; used only with CLK_SW_TIMEOUT_EN.

Ports:
- clk, input, 1: control clock; all logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 1: switch request; sampled only in IDLE.
- req_sel, input, 1: target select, sampled with req.
- frame_idle, input, 1: high while the pipeline is between frames.
- sel, output, 1: drives the clock mux select (1 = clk1, 0 = clk2).
- gate_en, output, 1: downstream clock enable; low during a switch.
- busy, output, 1: high from request accept until the completion cycle.
- ack, output, 1: one-cycle pulse when a request completes.
- err, output, 1: one-cycle pulse on timeout abort; constant 0 without CLK_SW_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, sel=RESET_SEL, gate_en=1, busy=0, ack=0, err=0, counters=0. Reset asserted mid-switch aborts immediately to these values, with no ack.
- IDLE: when req=1 at cycle t:
  - If req_sel==sel, go to DONE (no-op; gate_en never drops). ack=1 at t+1.
  - Otherwise latch req_sel and go to WAIT_IDLE; busy=1 from t+1.
- WAIT_IDLE: stay until frame_idle=1, then go to GATE_OFF. gate_en stays 1 while waiting.
- GATE_OFF: gate_en=0 for exactly SETTLE_CYCLES cycles, then go to SWITCH. frame_idle dropping here is ignored, since the gate is already off.
- SWITCH: one cycle; sel <= latched req_sel, visible the next cycle. gate_en=0.
- SETTLE_ON: gate_en=0 for SETTLE_CYCLES cycles, then go to DONE.
- DONE: one cycle; ack=1, gate_en=1, busy=0. Next state is IDLE.
- Latency: with frame_idle already high at t+1, gate_en falls at t+2, sel changes at t+3+S, ack and gate_en rise at t+3+2S (S=SETTLE_CYCLES). For S=8, ack is at t+19.
- Requests arriving in any state other than IDLE (including DONE) are dropped, not queued.
- req held high continuously re-triggers in each IDLE cycle; the requester deasserts on ack.
- Invariant: sel changes only while gate_en=0, and only in the cycle after SWITCH.

Optional Feature:
- Macro: CLK_SW_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_IDLE.
  - If TIMEOUT_CYCLES cycles elapse without frame_idle, go to DONE with err=1 and ack=0; sel and gate_en are unchanged.
  - frame_idle and timeout in the same cycle: frame_idle wins.
- Undefined: WAIT_IDLE waits indefinitely; err is tied to 0; no timeout counter is instantiated.

Decomposition:
- Package clk_ctrl_pkg:
  - State encoding constants: IDLE, WAIT_IDLE, GATE_OFF, SWITCH, SETTLE_ON, DONE.
  - SEL_CLK1=1, SEL_CLK2=0.
  - Counter width constant of 8 bits for settle counting.
- Sub-module clk_sw_timer:
  - Loadable down-counter with load and zero-flag outputs.
  - One instance is reused for both settle phases.
  - A second instance provides the timeout when CLK_SW_TIMEOUT_EN is defined.

Test Plan:
- Reset then idle: rst held 2 cycles -> sel=1, gate_en=1, busy=0, ack=0, err=0.
- No-op request: req=1, req_sel=1 at t with sel=1 -> ack at t+1; gate_en never 0; sel stays 1.
- Normal switch, S=8: frame_idle=1, req=1, req_sel=0 at t -> gate_en=0 over t+2..t+18; sel=0 from t+11; ack and gate_en=1 at t+19.
- Deferred switch: frame_idle=0 until t+50, req at t -> busy from t+1; gate_en stays 1 until t+51; ack at t+68.
- Drop and reset: second req during GATE_OFF is ignored (exactly one ack). rst pulsed during SETTLE_ON -> next cycle sel=RESET_SEL, gate_en=1, no ack.
- Timeout (CLK_SW_TIMEOUT_EN, TIMEOUT_CYCLES=16): frame_idle=0 forever, req at t -> err pulse near t+17, ack never; sel unchanged; gate_en never 0.
